uart_rx_buf_ctrl: RTL and testbench
===================================

UART_RX_BUF_CTRL -- requirements
Module: uart_rx_buf_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the receive FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter TO_CYCLES, default 640, giving the character-timeout length in bclk cycles (4 frames x 10 bits x 16).
REQ-003 The block SHALL have port bclk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port rx_en, input, 1 bit: receive enable; frames are discarded while low.
REQ-006 The block SHALL have port rx_done, input, 1 bit: one-cycle frame-complete pulse from the receiver.
REQ-007 The block SHALL have port rx_data, input, 8 bits: received byte, valid in the rx_done cycle.
REQ-008 The block SHALL have port rx_err, input, 1 bit: frame/parity/sample error, valid in the rx_done cycle.
REQ-009 The block SHALL have port rd_req, input, 1 bit: pop request from the bus side.
REQ-010 The block SHALL have port thresh, input, 4 bits: interrupt fill level; 0 disables the level interrupt.
REQ-011 The block SHALL have port ovr_clr, input, 1 bit: clears overrun.
REQ-012 The block SHALL have port rd_data, output, 8 bits: popped byte.
REQ-013 The block SHALL have port rd_err, output, 1 bit: error tag of the popped byte.
REQ-014 The block SHALL have port rd_valid, output, 1 bit: one-cycle pulse that marks rd_data/rd_err as valid.
REQ-015 The block SHALL have port fifo_cnt, output, 5 bits: current occupancy.
REQ-016 The block SHALL have ports empty and full, outputs, 1 bit each: occupancy flags.
REQ-017 The block SHALL have port overrun, output, 1 bit: sticky overrun flag.
REQ-018 The block SHALL have port err_cnt, output, 8 bits: saturating count of errored frames.
REQ-019 The block SHALL have port irq, output, 1 bit: registered interrupt.

Function
REQ-020 A push SHALL occur when rx_done=1 and rx_en=1: {rx_err, rx_data} is written and fifo_cnt increments on the next edge (1-cycle latency).
REQ-021 A pop SHALL occur when rd_req=1 and empty=0: rd_data/rd_err are registered and rd_valid=1 the next cycle. rd_valid SHALL be 0 in all other cycles, and rd_data SHALL hold its last value.
REQ-022 rd_req while empty SHALL be ignored: no pointer change, rd_valid stays 0, even if a push occurs in the same cycle.
REQ-023 Push and pop in the same cycle while not empty SHALL both execute, leaving fifo_cnt unchanged. This includes the full case, where no overrun is raised.
REQ-024 Push while full without a pop SHALL drop the frame and set overrun; fifo_cnt SHALL stay DEPTH.
REQ-025 ovr_clr SHALL clear overrun the next cycle. A simultaneous new overrun SHALL win and leave overrun set.
REQ-026 err_cnt SHALL increment on each push with rx_err=1, including dropped frames, and SHALL saturate at 255.
REQ-027 Pointers SHALL wrap modulo DEPTH. full SHALL equal (fifo_cnt==DEPTH) and empty SHALL equal (fifo_cnt==0).
REQ-028 irq SHALL be registered as (thresh!=0 && fifo_cnt>=thresh) | overrun | to_flag.
REQ-029 Deasserting rx_en SHALL NOT flush the FIFO, and pops SHALL continue normally.

Reset
REQ-030 While rst=1 at a bclk edge, the block SHALL clear pointers and fifo_cnt, set empty=1, and force all other outputs to 0. The timeout FSM SHALL go to TO_IDLE. FIFO storage SHALL need no reset.
REQ-031 Reset asserted mid-frame or mid-pop SHALL discard everything. No rd_valid pulse SHALL follow reset.

Configuration
REQ-032 Macro UART_RX_TIMEOUT_EN defined: the block SHALL have an output to_flag (1 bit) and a timeout FSM with states TO_IDLE, TO_COUNT and TO_FIRED. The FSM SHALL transition as follows:
- TO_IDLE -> TO_COUNT when fifo non-empty.
- TO_COUNT: counter SHALL restart on any push or pop; -> TO_FIRED at TO_CYCLES-1; -> TO_IDLE if empty.
- TO_FIRED: to_flag=1; -> TO_IDLE on any pop or push.
REQ-033 Macro not defined: there SHALL be no to_flag port, FSM or counter, and irq SHALL omit the timeout term.

Structure
REQ-034 Shared package uart_pkg SHALL hold the DEPTH default, TO_CYCLES default, timeout state encoding and the fifo entry width (9).
REQ-035 Storage and pointers SHALL be a sub-module uart_rx_fifo (sync write, registered read). Control, flags, err_cnt, irq and timeout SHALL stay in the top level.

Verification
REQ-036 3 pushes (0x11, 0x22, 0x33), then 3 rd_req -> rd_data 0x11, 0x22, 0x33, each with a 1-cycle rd_valid; fifo_cnt 3->0; empty=1.
REQ-037 9 pushes at DEPTH=8 -> full=1 after 8; 9th dropped, overrun=1, irq=1; pops return the first 8 bytes; ovr_clr -> overrun=0.
REQ-038 Full FIFO with push+pop in the same cycle -> fifo_cnt stays 8, overrun stays 0, oldest byte out.
REQ-039 thresh=4: 3 pushes -> irq=0; 4th push -> irq=1 the cycle after fifo_cnt=4; one pop -> irq=0.
REQ-040 Pushes with rx_err=1 x300 (with pops) -> err_cnt=255; rd_err=1 on those bytes; rx_en=0 push -> no count change.
REQ-041 With UART_RX_TIMEOUT_EN: 1 push, idle 640 cycles -> to_flag=1 and irq=1; one pop -> to_flag=0. rst mid-count -> all zero next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and the character-timeout state encoding for the UART receive buffer.
package uart_pkg;
  localparam int DEPTH_DEF     = 8;
  localparam int TO_CYCLES_DEF = 640;
  localparam int ENTRY_W       = 9;  // {err, data[7:0]}
  localparam int CNT_W         = 5;

  typedef enum logic [1:0] {
    TO_IDLE  = 2'd0,
    TO_COUNT = 2'd1,
    TO_FIRED = 2'd2
  } to_state_e;
endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO storage and pointers: synchronous write, registered read on pop.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               bclk,
  input  logic               rst,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  output logic [ENTRY_W-1:0] rdata_o,
  output logic [CNT_W-1:0]   cnt_o
);
  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ENTRY_W-1:0] rdata_q;

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge bclk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        rdata_q  <= mem_q[rd_ptr_q];
      end
    end
  end

  // NOTE: storage is deliberately not reset; entries are only read after being written.
  always_ff @(posedge bclk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = rdata_q;
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/uart_rx_buf_ctrl.sv
// UART receive buffer controller: push/pop control, flags, overrun, error count and irq.
// Define UART_RX_TIMEOUT_EN to add the character-timeout FSM and the to_flag output.
module uart_rx_buf_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic             bclk,
  input  logic             rst,
  input  logic             rx_en,
  input  logic             rx_done,
  input  logic [7:0]       rx_data,
  input  logic             rx_err,
  input  logic             rd_req,
  input  logic [3:0]       thresh,
  input  logic             ovr_clr,
  output logic [7:0]       rd_data,
  output logic             rd_err,
  output logic             rd_valid,
  output logic [CNT_W-1:0] fifo_cnt,
  output logic             empty,
  output logic             full,
  output logic             overrun,
  output logic [7:0]       err_cnt,
`ifdef UART_RX_TIMEOUT_EN
  output logic             to_flag,
`endif
  output logic             irq
);
  logic               push_req, pop, push_ok, ovr_set;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               rd_valid_q, overrun_q, irq_q, irq_d;
  logic [7:0]         err_cnt_q;

  assign empty    = (fifo_cnt == '0);
  assign full     = (fifo_cnt == CNT_W'(DEPTH));
  assign push_req = rx_done & rx_en;
  assign pop      = rd_req & ~empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign push_ok  = push_req & (~full | pop);
  assign ovr_set  = push_req & full & ~pop;

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .bclk    (bclk),
    .rst     (rst),
    .push_i  (push_ok),
    .pop_i   (pop),
    .wdata_i ({rx_err, rx_data}),
    .rdata_o (fifo_rdata),
    .cnt_o   (fifo_cnt)
  );

  assign rd_err  = fifo_rdata[ENTRY_W-1];
  assign rd_data = fifo_rdata[7:0];

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES);

  to_state_e         to_state_q, to_state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              activity;

  assign activity = push_ok | pop;
  assign to_flag  = (to_state_q == TO_FIRED);

  always_comb begin
    to_state_d = to_state_q;
    to_cnt_d   = to_cnt_q;
    unique case (to_state_q)
      TO_IDLE: begin
        to_cnt_d = '0;
        if (!empty) to_state_d = TO_COUNT;
      end
      TO_COUNT: begin
        if (empty) begin
          to_state_d = TO_IDLE;
          to_cnt_d   = '0;
        end else if (activity) begin
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
          to_state_d = TO_FIRED;
          to_cnt_d   = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      TO_FIRED: if (activity) to_state_d = TO_IDLE;
      default:  to_state_d = TO_IDLE;
    endcase
  end

  always_ff @(posedge bclk) begin
    if (rst) begin
      to_state_q <= TO_IDLE;
      to_cnt_q   <= '0;
    end else begin
      to_state_q <= to_state_d;
      to_cnt_q   <= to_cnt_d;
    end
  end
`endif

  always_comb begin
    irq_d = ((thresh != 4'd0) && (fifo_cnt >= {1'b0, thresh})) || overrun_q;
`ifdef UART_RX_TIMEOUT_EN
    irq_d = irq_d || to_flag;
`endif
  end

  always_ff @(posedge bclk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      err_cnt_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      rd_valid_q <= pop;
      irq_q      <= irq_d;
      if (ovr_set)      overrun_q <= 1'b1;
      else if (ovr_clr) overrun_q <= 1'b0;
      if (push_req && rx_err && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign rd_valid = rd_valid_q;
  assign overrun  = overrun_q;
  assign err_cnt  = err_cnt_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_uart_rx_buf_ctrl.sv
// Directed self-checking bench for uart_rx_buf_ctrl at DEPTH=8, TO_CYCLES=640.
module tb_uart_rx_buf_ctrl;
  logic       bclk = 1'b0;
  logic       rst = 1'b1, rx_en = 1'b1, rx_done = 1'b0, rx_err = 1'b0, rd_req = 1'b0, ovr_clr = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [3:0] thresh = 4'd0;
  logic [7:0] rd_data, err_cnt;
  logic       rd_err, rd_valid, empty, full, overrun, irq;
  logic [4:0] fifo_cnt;
`ifdef UART_RX_TIMEOUT_EN
  logic       to_flag;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 bclk = ~bclk;

  uart_rx_buf_ctrl #(.DEPTH(8), .TO_CYCLES(640)) dut (
    .bclk     (bclk),
    .rst      (rst),
    .rx_en    (rx_en),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .rx_err   (rx_err),
    .rd_req   (rd_req),
    .thresh   (thresh),
    .ovr_clr  (ovr_clr),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .rd_valid (rd_valid),
    .fifo_cnt (fifo_cnt),
    .empty    (empty),
    .full     (full),
    .overrun  (overrun),
    .err_cnt  (err_cnt),
`ifdef UART_RX_TIMEOUT_EN
    .to_flag  (to_flag),
`endif
    .irq      (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  // One clock with the given push/pop strobes; strobes drop afterwards.
  task automatic step(input logic done, input logic [7:0] d, input logic e, input logic rd);
    rx_done = done;
    rx_data = d;
    rx_err  = e;
    rd_req  = rd;
    tick();
    rx_done = 1'b0;
    rx_err  = 1'b0;
    rd_req  = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_cnt", fifo_cnt, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_ovr", overrun, 0);
    check("rst_err", err_cnt, 0);
    check("rst_irq", irq, 0);
    check("rst_data", rd_data, 0);
    rst = 1'b0;
    tick();

    // Basic push/pop ordering
    step(1, 8'h11, 0, 0); check("p1_cnt", fifo_cnt, 1); check("p1_empty", empty, 0);
    step(1, 8'h22, 0, 0); check("p2_cnt", fifo_cnt, 2);
    step(1, 8'h33, 0, 0); check("p3_cnt", fifo_cnt, 3);
    step(0, 0, 0, 1); check("r1_valid", rd_valid, 1); check("r1_data", rd_data, 8'h11); check("r1_cnt", fifo_cnt, 2);
    step(0, 0, 0, 1); check("r2_valid", rd_valid, 1); check("r2_data", rd_data, 8'h22); check("r2_cnt", fifo_cnt, 1);
    step(0, 0, 0, 1); check("r3_valid", rd_valid, 1); check("r3_data", rd_data, 8'h33); check("r3_cnt", fifo_cnt, 0);
    check("r3_empty", empty, 1);
    step(0, 0, 0, 0); check("idle_valid", rd_valid, 0); check("hold_data", rd_data, 8'h33);

    // Read while empty is ignored, even with a simultaneous push
    step(0, 0, 0, 1); check("rde_valid", rd_valid, 0); check("rde_cnt", fifo_cnt, 0);
    step(1, 8'h44, 0, 1); check("rdep_valid", rd_valid, 0); check("rdep_cnt", fifo_cnt, 1);
    step(0, 0, 0, 1); check("rdep_data", rd_data, 8'h44); check("rdep_cnt0", fifo_cnt, 0);

    // Fill, overflow, drain, clear overrun
    for (int i = 0; i < 8; i++) step(1, 8'hA0 + 8'(i), 0, 0);
    check("fill_cnt", fifo_cnt, 8); check("fill_full", full, 1); check("fill_ovr", overrun, 0);
    step(1, 8'hEE, 0, 0);
    check("ovf_cnt", fifo_cnt, 8); check("ovf_ovr", overrun, 1);
    step(0, 0, 0, 0); check("ovf_irq", irq, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1);
      check("drain_data", rd_data, 8'hA0 + i);
    end
    check("drain_empty", empty, 1); check("drain_ovr_sticky", overrun, 1);
    ovr_clr = 1'b1; step(0, 0, 0, 0); ovr_clr = 1'b0;
    check("clr_ovr", overrun, 0);
    step(0, 0, 0, 0); check("clr_irq", irq, 0);

    // Full FIFO: push+pop together, then overrun beats ovr_clr
    for (int i = 0; i < 8; i++) step(1, 8'hB0 + 8'(i), 0, 0);
    step(1, 8'hC0, 0, 1);
    check("pp_cnt", fifo_cnt, 8); check("pp_ovr", overrun, 0);
    check("pp_valid", rd_valid, 1); check("pp_data", rd_data, 8'hB0);
    ovr_clr = 1'b1; step(1, 8'hEE, 0, 0); ovr_clr = 1'b0;
    check("ovr_wins", overrun, 1); check("ovr_wins_cnt", fifo_cnt, 8);
    ovr_clr = 1'b1; step(0, 0, 0, 0); ovr_clr = 1'b0;
    check("ovr_clr2", overrun, 0);
    for (int i = 1; i < 8; i++) begin
      step(0, 0, 0, 1);
      check("pp_drain", rd_data, 8'hB0 + i);
    end
    step(0, 0, 0, 1); check("pp_last", rd_data, 8'hC0); check("pp_empty", empty, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Threshold interrupt
    thresh = 4'd4;
    step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0); step(1, 8'h03, 0, 0);
    step(0, 0, 0, 0); check("th3_irq", irq, 0);
    step(1, 8'h04, 0, 0); check("th4_cnt", fifo_cnt, 4); check("th4_irq_lag", irq, 0);
    step(0, 0, 0, 0); check("th4_irq", irq, 1);
    step(0, 0, 0, 1); check("thp_irq_lag", irq, 1);
    step(0, 0, 0, 0); check("thp_irq", irq, 0);
    thresh = 4'd0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    check("th_empty", empty, 1);

    // Error counting and saturation
    for (int i = 0; i < 10; i++) step(1, 8'(i), 1, 1);
    check("e10_cnt", err_cnt, 10); check("e10_fifo", fifo_cnt, 1);
    check("e10_rderr", rd_err, 1); check("e10_data", rd_data, 8'h08);
    rx_en = 1'b0;
    step(1, 8'h77, 1, 0); check("dis_errcnt", err_cnt, 10); check("dis_fifo", fifo_cnt, 1);
    step(0, 0, 0, 1); check("dis_pop_valid", rd_valid, 1); check("dis_pop_data", rd_data, 8'h09);
    check("dis_pop_cnt", fifo_cnt, 0);
    rx_en = 1'b1;
    for (int i = 0; i < 290; i++) step(1, 8'(i), 1, 1);
    check("sat_errcnt", err_cnt, 255);
    step(1, 8'h5A, 0, 1); check("sat_rderr", rd_err, 1);
    step(0, 0, 0, 1); check("clean_data", rd_data, 8'h5A); check("clean_rderr", rd_err, 0);
    check("sat_hold", err_cnt, 255);

    // Reset during push and pop
    step(1, 8'h61, 0, 0); step(1, 8'h62, 0, 0);
    rst = 1'b1; step(1, 8'h63, 1, 1);
    check("mrst_cnt", fifo_cnt, 0); check("mrst_valid", rd_valid, 0); check("mrst_empty", empty, 1);
    check("mrst_err", err_cnt, 0); check("mrst_data", rd_data, 0);
    rst = 1'b0; step(0, 0, 0, 0);
    check("postrst_valid", rd_valid, 0); check("postrst_cnt", fifo_cnt, 0);

`ifdef UART_RX_TIMEOUT_EN
    step(1, 8'h90, 0, 0);
    for (int i = 0; i < 600; i++) tick();
    check("to_early", to_flag, 0);
    for (int i = 0; i < 50; i++) tick();
    check("to_flag", to_flag, 1); check("to_irq", irq, 1);
    step(0, 0, 0, 1); check("to_pop_clr", to_flag, 0); check("to_pop_data", rd_data, 8'h90);
    step(1, 8'h91, 0, 0);
    for (int i = 0; i < 100; i++) tick();
    rst = 1'b1; tick();
    check("to_rst_flag", to_flag, 0); check("to_rst_cnt", fifo_cnt, 0); check("to_rst_irq", irq, 0);
    rst = 1'b0; tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
